// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: push/pop handshake, status and RAM port bundle for ram_fifo_ctrl
interface ram_fifo_ctrl_if;
  logic        flush, in_valid, in_ready, out_valid, out_ready, almost_full, ram_wen, ram_ren;
  logic [31:0] in_data, in_mask, out_data, ram_din, ram_wenb, ram_dout;
  logic [9:0]  level;
  logic [8:0]  ram_waddr, ram_raddr;
  modport slave (
    input  flush, in_valid, in_data, in_mask, out_ready, ram_dout,
    output in_ready, out_valid, out_data, level, almost_full,
           ram_wen, ram_ren, ram_waddr, ram_raddr, ram_din, ram_wenb
  );
  modport master (
    output flush, in_valid, in_data, in_mask, out_ready, ram_dout,
    input  in_ready, out_valid, out_data, level, almost_full,
           ram_wen, ram_ren, ram_waddr, ram_raddr, ram_din, ram_wenb
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: 512x32 RAM-backed FIFO with a 2-entry output queue hiding RAM read latency
module ram_fifo_ctrl #(
  parameter int AFULL_THRESH = 480
) (
  input logic            clk,
  input logic            rst_n,
  ram_fifo_ctrl_if.slave bus
);
  logic [8:0]  wptr, rptr;
  logic [9:0]  ram_cnt, level_n;
  logic [1:0]  q_cnt, tail;
  logic [31:0] q0, q1;
  logic        inflight, af, push, pop, rd;
  assign bus.level       = ram_cnt + 10'(inflight) + 10'(q_cnt);
  assign bus.in_ready    = rst_n & ~bus.flush & (bus.level < 10'd512);
  assign bus.out_valid   = rst_n & (q_cnt != 2'd0);
  assign bus.out_data    = q0;
  assign bus.almost_full = af;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  // only issue a read when the queue is guaranteed a free slot when the data returns
  assign rd = rst_n & ~bus.flush & (ram_cnt != 10'd0) &
              (3'(q_cnt) + 3'(inflight) < 3'd2 + 3'(pop));
  assign bus.ram_wen   = ~push;
  assign bus.ram_ren   = ~rd;
  assign bus.ram_waddr = wptr;
  assign bus.ram_raddr = rptr;
  assign bus.ram_din   = bus.in_data;
  assign bus.ram_wenb  = bus.in_mask;
  assign level_n = bus.level + 10'(push) - 10'(pop);
  assign tail    = q_cnt - 2'(pop);
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      q_cnt    <= '0;
      af       <= 1'b0;
    end else begin
      wptr     <= wptr + 9'(push);
      rptr     <= rptr + 9'(rd);
      ram_cnt  <= ram_cnt + 10'(push) - 10'(rd);
      inflight <= rd;
      q_cnt    <= q_cnt + 2'(inflight) - 2'(pop);
      af       <= level_n >= 10'(AFULL_THRESH);
    end
  end
  // queue storage needs no reset: q_cnt alone decides validity
  always_ff @(posedge clk) begin
    q0 <= (inflight && tail == 2'd0) ? bus.ram_dout : pop ? q1 : q0;
    q1 <= (inflight && tail == 2'd1) ? bus.ram_dout : q1;
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: scoreboard bench for ram_fifo_ctrl with a behavioural 512x32 RAM
module tb_ram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  ram_fifo_ctrl_if bus();
  ram_fifo_ctrl #(.AFULL_THRESH(480)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] mem [512];
  logic [31:0] shadow [512];
  always @(posedge clk) begin
    if (!bus.ram_wen) mem[bus.ram_waddr] <= (mem[bus.ram_waddr] & ~bus.ram_wenb) | (bus.ram_din & bus.ram_wenb);
    if (!bus.ram_ren) bus.ram_dout <= mem[bus.ram_raddr];
  end

  int checks = 0, errors = 0;
  int exp_level = 0, npop = 0, wwraps = 0, rwraps = 0;
  logic [8:0] exp_wptr = '0, exp_rptr = '0;
  logic [31:0] sb [$];
  logic pu, po, after_rst = 1'b0;
  logic [31:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    pu = bus.in_valid && bus.in_ready;
    po = bus.out_valid && bus.out_ready;
    chk("in_ready", 32'(bus.in_ready), 32'(rst_n && !bus.flush && exp_level < 512));
    chk("level", 32'(bus.level), exp_level);
    chk("almost_full", 32'(bus.almost_full), 32'(exp_level >= 480));
    chk("ram_wen", 32'(bus.ram_wen), 32'(!pu));
    if (after_rst) begin
      chk("rst_waddr", 32'(bus.ram_waddr), 0);
      chk("rst_raddr", 32'(bus.ram_raddr), 0);
    end
    if (!rst_n || exp_level == 0) chk("out_valid_idle", 32'(bus.out_valid), 0);
    if (!rst_n || bus.flush) chk("ren_blocked", 32'(bus.ram_ren), 1);
    if (pu) begin
      chk("waddr", 32'(bus.ram_waddr), 32'(exp_wptr));
      chk("ram_din", bus.ram_din, bus.in_data);
      chk("ram_wenb", bus.ram_wenb, bus.in_mask);
      e = (shadow[exp_wptr] & ~bus.in_mask) | (bus.in_data & bus.in_mask);
      shadow[exp_wptr] = e;
    end
    if (!bus.ram_ren) chk("raddr", 32'(bus.ram_raddr), 32'(exp_rptr));
    if (po) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("out_data", bus.out_data, sb.pop_front());
      npop++;
    end
    after_rst = !rst_n;
    if (!rst_n || bus.flush) begin
      sb.delete();
      exp_level = 0;
      exp_wptr = '0;
      exp_rptr = '0;
    end else begin
      if (pu) begin
        sb.push_back(e);
        if (exp_wptr == 9'd511) wwraps++;
        exp_wptr++;
      end
      if (!bus.ram_ren) begin
        if (exp_rptr == 9'd511) rwraps++;
        exp_rptr++;
      end
      exp_level = exp_level + int'(pu) - int'(po);
    end
  end

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 700 && bus.level != 0; i++) step();
    chk("drain_level", 32'(bus.level), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  int gaps, p0;
  logic seen;
  initial begin
    for (int i = 0; i < 512; i++) begin mem[i] = '0; shadow[i] = '0; end
    rst_n = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.in_mask = '1; bus.out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    // single word latency through an empty FIFO
    bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_wen", 32'(bus.ram_wen), 0);
    chk("t1_waddr", 32'(bus.ram_waddr), 0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_ren", 32'(bus.ram_ren), 0);
    chk("t1_raddr", 32'(bus.ram_raddr), 0);
    chk("t1_level", 32'(bus.level), 1);
    step();
    @(negedge clk);
    chk("t1_early_valid", 32'(bus.out_valid), 0);
    step();
    @(negedge clk);
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_data", bus.out_data, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t1_level_after", 32'(bus.level), 0);
    step();
    // fill to full with no pops
    bus.out_ready = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'h100 + i;
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("full_level", 32'(bus.level), 512);
    chk("full_af", 32'(bus.almost_full), 1);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_out_valid", 32'(bus.out_valid), 1);
    step();
    drain();
    // streaming with simultaneous push and pop, crossing the address wrap twice
    wwraps = 0; rwraps = 0; gaps = 0; seen = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'hA000_0000 + i;
      step();
      if (seen && !bus.out_valid) gaps++;
      seen |= bus.out_valid;
    end
    chk("stream_gaps", gaps, 0);
    drain();
    chk("stream_wwraps", wwraps, 2);
    chk("stream_rwraps", rwraps, 2);
    // flush with a read in flight and the queue occupied
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'hF0 + i;
      if (i == 2) begin
        @(negedge clk);
        chk("fl_ren_before", 32'(bus.ram_ren), 0);
      end
      step();
    end
    bus.in_valid = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_valid_before", 32'(bus.out_valid), 1);
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h5A5A_0001;
    @(negedge clk);
    chk("fl_level", 32'(bus.level), 0);
    chk("fl_out_valid", 32'(bus.out_valid), 0);
    chk("fl_waddr", 32'(bus.ram_waddr), 0);
    chk("fl_wen", 32'(bus.ram_wen), 0);
    step();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && !bus.out_valid; i++) step();
    chk("fl_first", bus.out_data, 32'h5A5A_0001);
    drain();
    // reset in the middle of traffic
    bus.out_ready = 1'b0;
    for (int i = 0; i < 37; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'hC00 + i;
      step();
    end
    bus.in_data = 32'hBAD; bus.out_ready = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("rs_level_before", 32'(bus.level), 37);
    chk("rs_in_ready", 32'(bus.in_ready), 0);
    chk("rs_wen", 32'(bus.ram_wen), 1);
    chk("rs_ren", 32'(bus.ram_ren), 1);
    chk("rs_out_valid", 32'(bus.out_valid), 0);
    step();
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rs_level", 32'(bus.level), 0);
    chk("rs_af", 32'(bus.almost_full), 0);
    chk("rs_out_valid_after", 32'(bus.out_valid), 0);
    step();
    p0 = npop;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'hE0 + i;
      step();
    end
    drain();
    chk("rs_pops", npop - p0, 4);
    // partial-bit write mask
    bus.in_valid = 1'b1; bus.in_data = 32'h1234_5678; bus.in_mask = 32'h0000_FFFF; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("mask_wenb", bus.ram_wenb, 32'h0000_FFFF);
    chk("mask_wen", 32'(bus.ram_wen), 0);
    step();
    bus.in_mask = '1;
    drain();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
